// File: rtl/fx_div.sv
// Signed fixed-point divider, iterative radix-2 restoring core, valid/ready on both sides.
// Define FXDIV_ROUND_EN to round the quotient magnitude half away from zero instead of truncating.
module fx_div #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_WIDTH = 64,
  parameter int unsigned QFRAC     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [NUM_WIDTH-1:0] numerator,
  input  logic [WIDTH-1:0]     denominator,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [WIDTH-1:0]     result,
  output logic                 div_by_zero
);

  localparam int unsigned CNT_W = $clog2(NUM_WIDTH + 1);
  localparam int unsigned MAG_W = NUM_WIDTH + 1;

  localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(1) << (WIDTH - 1);
  localparam logic [MAG_W-1:0] POS_LIM = NEG_LIM - MAG_W'(1);
  localparam logic [WIDTH-1:0] RES_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] RES_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // QFRAC only documents where the caller placed the binary point.
  if (QFRAC > WIDTH) begin : g_qfrac_chk
    $error("fx_div: QFRAC exceeds WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_accept;
  logic                   w_last;

  logic                   r_valid_out;
  logic                   r_ready_out;
  logic [WIDTH-1:0]       r_result;
  logic                   r_div_by_zero;

  logic [CNT_W-1:0]       r_cnt;
  logic [NUM_WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]       r_rem;
  logic [WIDTH-1:0]       r_den;
  logic                   r_neg;
  logic                   r_num_neg;
  logic                   r_dbz;

  logic [NUM_WIDTH-1:0]   w_num_mag;
  logic [WIDTH-1:0]       w_den_mag;
  logic [WIDTH:0]         w_rem_sh;
  logic                   w_ge;
  logic                   w_round;
  logic [MAG_W-1:0]       w_qmag;
  logic [WIDTH-1:0]       w_res;

  assign valid_out   = r_valid_out;
  assign ready_out   = r_ready_out;
  assign result      = r_result;
  assign div_by_zero = r_div_by_zero;

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid_in && r_ready_out) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == CNT_W'(NUM_WIDTH)) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (ready_in) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; handshake outputs follow the next state so they are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_valid_out <= 1'b0;
      r_ready_out <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_valid_out <= (w_state_nxt == S_DONE);
      r_ready_out <= (w_state_nxt == S_IDLE);
    end
  end

  // Magnitudes fit unsigned in the operand width, including the most-negative value.
  always_comb begin
    w_num_mag = numerator[NUM_WIDTH-1] ? (~numerator + NUM_WIDTH'(1)) : numerator;
    w_den_mag = denominator[WIDTH-1] ? (~denominator + WIDTH'(1)) : denominator;
    w_rem_sh  = {r_rem, r_q[NUM_WIDTH-1]};
    w_ge      = (w_rem_sh >= {1'b0, r_den});
`ifdef FXDIV_ROUND_EN
    w_round   = ({r_rem, 1'b0} >= {1'b0, r_den});
`else
    w_round   = 1'b0;
`endif
    w_qmag    = {1'b0, r_q} + MAG_W'(w_round);
    if (r_dbz) begin
      w_res = r_num_neg ? RES_MIN : RES_MAX;
    end else if (r_neg) begin
      w_res = (w_qmag > NEG_LIM) ? RES_MIN : WIDTH'(~w_qmag + MAG_W'(1));
    end else begin
      w_res = (w_qmag > POS_LIM) ? RES_MAX : WIDTH'(w_qmag);
    end
  end

  // Restoring iteration: dividend shifts out of r_q while quotient bits shift in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_q           <= '0;
      r_rem         <= '0;
      r_den         <= '0;
      r_neg         <= 1'b0;
      r_num_neg     <= 1'b0;
      r_dbz         <= 1'b0;
      r_result      <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt     <= '0;
        r_q       <= w_num_mag;
        r_rem     <= '0;
        r_den     <= w_den_mag;
        r_neg     <= numerator[NUM_WIDTH-1] ^ denominator[WIDTH-1];
        r_num_neg <= numerator[NUM_WIDTH-1];
        r_dbz     <= (denominator == '0);
      end else if ((r_state == S_BUSY) && !w_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_q   <= {r_q[NUM_WIDTH-2:0], w_ge};
        r_rem <= w_ge ? WIDTH'(w_rem_sh - {1'b0, r_den}) : WIDTH'(w_rem_sh);
      end
      if (w_last) begin
        r_result      <= w_res;
        r_div_by_zero <= r_dbz;
      end
    end
  end

endmodule

// File: tb/tb_fx_div.sv
// Scoreboard bench for fx_div: driver pushes expected results at accept, monitor pops on output handshake.
module tb_fx_div;

  localparam int LAT = 65;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [63:0] numerator = '0;
  logic [31:0] denominator = '0;
  logic        valid_out;
  logic        ready_in = 1'b1;
  logic [31:0] result;
  logic        div_by_zero;

  fx_div dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .numerator   (numerator),
    .denominator (denominator),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          acc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input string tag, input logic [63:0] n, input logic [31:0] d,
                       input logic [31:0] er, input logic ed, input bit push);
    int budget;
    budget = 0;
    @(negedge clk);
    numerator   = n;
    denominator = d;
    valid_in    = 1'b1;
    while (!ready_out && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    if (!ready_out) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: ready_out never rose within %0d cycles", tag, budget);
      valid_in = 1'b0;
      return;
    end
    if (push) sb.push_back('{er, ed, cyc + 1, tag});
    @(posedge clk);
    @(negedge clk);
    valid_in    = 1'b0;
    numerator   = {$urandom, $urandom};
    denominator = $urandom;
  endtask

  // Monitor: compares every presented result against the oldest expectation.
  bit prev_v = 1'b0;
  bit post_hs = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v  = 1'b0;
      post_hs = 1'b0;
    end else begin
      if (post_hs) begin
        check("valid_out_drop", 64'(valid_out), 64'(0));
        check("ready_out_rise", 64'(ready_out), 64'(1));
        post_hs = 1'b0;
      end
      if (sb.size() > 0 && sb[0].acc <= cyc)
        check({sb[0].tag, "_ready_low"}, 64'(ready_out), 64'(0));
      if (valid_out) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid: valid_out=1 with no accepted op (cycle %0d)", cyc);
        end else begin
          if (!prev_v) check({sb[0].tag, "_latency"}, 64'(cyc - sb[0].acc), 64'(LAT));
          check({sb[0].tag, "_result"}, 64'(result), 64'(sb[0].res));
          check({sb[0].tag, "_dbz"}, 64'(div_by_zero), 64'(sb[0].dbz));
          if (ready_in) begin
            void'(sb.pop_front());
            post_hs = 1'b1;
          end
        end
      end
      prev_v = valid_out;
    end
  end

  task automatic drain();
    int budget;
    budget = 0;
    while (sb.size() > 0 && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results still outstanding", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  logic [31:0] exp_r100_8;
  logic [31:0] exp_r7_m2;

  initial begin
`ifdef FXDIV_ROUND_EN
    exp_r100_8 = 32'd13;
    exp_r7_m2  = 32'hFFFF_FFFC;
`else
    exp_r100_8 = 32'd12;
    exp_r7_m2  = 32'hFFFF_FFFD;
`endif
    repeat (3) @(negedge clk);
    check("rst_valid_out", 64'(valid_out), 64'(0));
    check("rst_ready_out", 64'(ready_out), 64'(1));
    check("rst_result", 64'(result), 64'(0));
    check("rst_dbz", 64'(div_by_zero), 64'(0));
    rst_n = 1'b1;

    issue("p100_7",   64'd100,                 32'd7,           32'd14,          1'b0, 1'b1);
    issue("m100_7",   64'hFFFF_FFFF_FFFF_FF9C, 32'd7,           32'hFFFF_FFF2,   1'b0, 1'b1);
    issue("m100_m7",  64'hFFFF_FFFF_FFFF_FF9C, 32'hFFFF_FFF9,   32'd14,          1'b0, 1'b1);
    issue("z_m3",     64'd0,                   32'hFFFF_FFFD,   32'd0,           1'b0, 1'b1);
    issue("p5_0",     64'd5,                   32'd0,           32'h7FFF_FFFF,   1'b1, 1'b1);
    issue("m5_0",     64'hFFFF_FFFF_FFFF_FFFB, 32'd0,           32'h8000_0000,   1'b1, 1'b1);
    issue("sat_p40",  64'h0000_0100_0000_0000, 32'd1,           32'h7FFF_FFFF,   1'b0, 1'b1);
    issue("sat_m63",  64'h8000_0000_0000_0000, 32'd1,           32'h8000_0000,   1'b0, 1'b1);
    issue("m63_m1",   64'h8000_0000_0000_0000, 32'hFFFF_FFFF,   32'h7FFF_FFFF,   1'b0, 1'b1);
    issue("m31_1",    64'hFFFF_FFFF_8000_0000, 32'd1,           32'h8000_0000,   1'b0, 1'b1);
    issue("p31_1",    64'h0000_0000_8000_0000, 32'd1,           32'h7FFF_FFFF,   1'b0, 1'b1);
    issue("p1000_dm", 64'd1000,                32'h8000_0000,   32'd0,           1'b0, 1'b1);
    issue("rnd100_8", 64'd100,                 32'd8,           exp_r100_8,      1'b0, 1'b1);
    issue("rnd7_m2",  64'd7,                   32'hFFFF_FFFE,   exp_r7_m2,       1'b0, 1'b1);
    drain();

    // Backpressure: second op held on valid_in through BUSY and DONE.
    ready_in = 1'b0;
    issue("bp_a", 64'd100, 32'd7, 32'd14, 1'b0, 1'b1);
    fork
      issue("bp_b", 64'd50, 32'd5, 32'd10, 1'b0, 1'b1);
      begin
        int budget;
        budget = 0;
        while (!valid_out && budget < 200) begin
          @(negedge clk);
          budget++;
        end
        if (!valid_out) begin
          checks++;
          errors++;
          $display("FAIL bp_wait: valid_out never rose within %0d cycles", budget);
        end
        repeat (10) @(negedge clk);
        ready_in = 1'b1;
      end
    join
    drain();

    // Abort an op mid-flight with an asynchronous reset.
    issue("abort", 64'd1000, 32'd10, 32'd100, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid_out", 64'(valid_out), 64'(0));
    check("abort_ready_out", 64'(ready_out), 64'(1));
    check("abort_result", 64'(result), 64'(0));
    check("abort_dbz", 64'(div_by_zero), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    issue("post_rst", 64'd9, 32'd3, 32'd3, 1'b0, 1'b1);
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
